// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, multiply sequencer states and default width
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FIX  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add 32x32 multiply sequencer driving an external ALU (optional MUL_SIGNED_EN)
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
`ifdef MUL_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_dataA,
  output logic [WIDTH-1:0]   alu_dataB,
  output logic [5:0]         alu_Signal,
  input  logic [WIDTH-1:0]   alu_dataOut
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] load_a, load_b;
  logic             accept, last_iter, carry;
`ifdef MUL_SIGNED_EN
  logic             neg_q;
  logic             neg_d;
`endif

  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // The ALU has no carry-out, so recover it: an unsigned add wrapped iff sum < hi.
  assign carry = (alu_dataOut < hi_q);
  assign hi_n  = {carry, alu_dataOut[WIDTH-1:1]};
  assign lo_n  = {alu_dataOut[0], lo_q[WIDTH-1:1]};

  assign alu_Signal = ALU_ADD;

`ifdef MUL_SIGNED_EN
  // Signed requests run the unsigned core on magnitudes and fix the sign afterwards.
  always_comb begin
    load_a = dataA;
    load_b = dataB;
    neg_d  = 1'b0;
    if (is_signed) begin
      if (dataA[WIDTH-1]) load_a = ~dataA + WIDTH'(1);
      if (dataB[WIDTH-1]) load_b = ~dataB + WIDTH'(1);
      neg_d = dataA[WIDTH-1] ^ dataB[WIDTH-1];
    end
  end
`else
  assign load_a = dataA;
  assign load_b = dataB;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE is always a single cycle unless a new start arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
`ifdef MUL_SIGNED_EN
      ST_RUN:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
`else
      ST_RUN:  if (last_iter) state_d = ST_DONE;
`endif
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status and ALU operand drive; operands are zero whenever the ALU is not ours.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    alu_dataA = '0;
    alu_dataB = '0;
    case (state_q)
      ST_RUN: begin
        busy      = 1'b1;
        alu_dataA = hi_q;
        alu_dataB = lo_q[0] ? mcand_q : '0;
      end
      ST_FIX:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Accumulator, counter and product register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      product <= '0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (accept) begin
      mcand_q <= load_a;
      hi_q    <= '0;
      lo_q    <= load_b;
      cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end else if (state_q == ST_RUN) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CNT_W'(1);
`ifndef MUL_SIGNED_EN
      if (last_iter) product <= {hi_n, lo_n};
`endif
    end
`ifdef MUL_SIGNED_EN
    else if (state_q == ST_FIX) begin
      product <= neg_q ? (~{hi_q, lo_q} + (2*WIDTH)'(1)) : {hi_q, lo_q};
    end
`endif
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

`ifdef MUL_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataA, dataB;
  logic        sgn;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
  logic [5:0]  alu_Signal;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_prod[$];
  int          exp_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: only ADD matters to this block.
  assign alu_dataOut = (alu_Signal == 6'b100000) ? alu_dataA + alu_dataB : 32'h0;

  alu_mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dataA      (dataA),
    .dataB      (dataB),
`ifdef MUL_SIGNED_EN
    .is_signed  (sgn),
`endif
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_dataA  (alu_dataA),
    .alu_dataB  (alu_dataB),
    .alu_Signal (alu_Signal),
    .alu_dataOut(alu_dataOut)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one request at the current falling edge; done is due LAT cycles later.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] e);
    start = 1'b1;
    dataA = a;
    dataB = b;
    sgn   = s;
    exp_prod.push_back(e);
    exp_cyc.push_back(cyc + LAT);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_prod.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_prod.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_prod.size());
      exp_prod.delete();
      exp_cyc.delete();
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_prod.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        chk("product", product, exp_prod.pop_front());
        chk("done_cycle", 64'(cyc), 64'(exp_cyc.pop_front()));
      end
    end
  end

  initial begin
    int x;
    reset = 1'b0;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    sgn   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_signal", 64'(alu_Signal), 64'h20);
    chk("rst_alu_a", 64'(alu_dataA), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 3x5, with an ignored start in RUN cycle 5.
    x = cyc;
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    chk("busy_first", 64'(busy), 64'd1);
    wait_until(x + 5);
    start = 1'b1;
    dataA = 32'd9;
    dataB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_until(x + LAT - 1);
    chk("busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    chk("busy_in_done", 64'(busy), 64'd0);
    drain();

    // Zero operand still completes at full latency.
    issue(32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0);
    drain();

    // All-ones carry path, then 7x6 accepted back-to-back in its DONE cycle.
    x = cyc;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    wait_until(x + LAT);
    issue(32'd7, 32'd6, 1'b0, 64'd42);
    drain();

    // Abort in RUN cycle 10, then a normal operation.
    x = cyc;
    issue(32'd5, 32'd5, 1'b0, 64'd25);
    wait_until(x + 10);
    reset = 1'b0;
    void'(exp_prod.pop_back());
    void'(exp_cyc.pop_back());
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_product", product, 64'd0);
    chk("abort_signal", 64'(alu_Signal), 64'h20);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd11, 32'd13, 1'b0, 64'd143);
    drain();

`ifdef MUL_SIGNED_EN
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    drain();
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
